// File: rtl/i2c_codec_target_if.sv
// Bus bundle for the I2C codec target: SCL/SDA in, ACK drive and register-write strobe out.
interface i2c_codec_target_if;
    logic       i2c_clk;
    logic       i2c_dat;
    logic       i2c_dat_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       nack_pulse;

    modport master (
        output i2c_clk, i2c_dat,
        input  i2c_dat_oe, wr_valid, wr_addr, wr_data, busy, nack_pulse
    );

    modport slave (
        input  i2c_clk, i2c_dat,
        output i2c_dat_oe, wr_valid, wr_addr, wr_data, busy, nack_pulse
    );
endinterface

// File: rtl/i2c_codec_target.sv
// Write-only I2C target decoding 3-byte codec frames {dev,w}, {reg[6:0],d[8]}, d[7:0]
// into one register-write strobe per frame; ACKs only frames addressed to DEV_ADDR.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_codec_target_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_over;
    logic       r_oe, r_wr_valid, r_busy, r_nack;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;

    logic       w_scl, w_sda, w_start, w_stop, w_rise, w_fall, w_last_bit;
    logic [7:0] w_byte;

    // Synchronizers reset to 1 so a released bus produces no spurious edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.i2c_clk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.i2c_dat};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_rise     = w_scl & ~r_scl_prev;
    assign w_fall     = ~w_scl & r_scl_prev;
    assign w_last_bit = w_rise && (r_cnt == 4'd7);
    assign w_byte     = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_byte1    <= 8'd0;
            r_over     <= 1'b0;
            r_oe       <= 1'b0;
            r_wr_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_nack     <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
        end else begin
            r_wr_valid <= 1'b0;
            r_nack     <= 1'b0;
            // Bus conditions win over bit sampling in the same cycle.
            if (w_start) begin
                r_state <= S_ADDR;
                r_cnt   <= 4'd0;
                r_oe    <= 1'b0;
                r_busy  <= 1'b1;
                r_over  <= 1'b0;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_BYTE1, S_BYTE2: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= w_last_bit ? 4'd0 : r_cnt + 4'd1;
                        end
                        if (w_last_bit) begin
                            if (r_state == S_ADDR) begin
                                if (w_byte == {DEV_ADDR, 1'b0}) begin
                                    r_state <= S_ACK_A;
                                end else begin
                                    r_nack  <= 1'b1;
                                    r_state <= S_IGNORE;
                                end
                            end else if (r_state == S_BYTE1) begin
                                r_state <= S_ACK_1;
                            end else begin
                                r_wr_valid <= 1'b1;
                                r_wr_addr  <= r_byte1[7:1];
                                r_wr_data  <= {r_byte1[0], w_byte};
                                r_state    <= S_ACK_2;
                            end
                        end
                    end
                    S_ACK_A, S_ACK_1, S_ACK_2: begin
                        // First SCL fall starts the ACK, the second one ends it.
                        if (w_fall) begin
                            if (!r_oe) begin
                                r_oe <= 1'b1;
                                if (r_state == S_ACK_1) r_byte1 <= r_shift;
                            end else begin
                                r_oe  <= 1'b0;
                                r_cnt <= 4'd0;
                                case (r_state)
                                    S_ACK_A: r_state <= S_BYTE1;
                                    S_ACK_1: r_state <= S_BYTE2;
                                    default: begin
                                        r_state <= S_IGNORE;
                                        r_over  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    S_IGNORE: begin
                        // Count 9-bit byte slots so bytes past the frame get a NACK strobe.
                        if (w_rise) begin
                            r_cnt <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
                            if (r_over && r_cnt == 4'd7) r_nack <= 1'b1;
                        end
                    end
                    default: begin
                        r_cnt <= 4'd0;
                        r_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.i2c_dat_oe = r_oe;
    assign bus.wr_valid   = r_wr_valid;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.busy       = r_busy;
    assign bus.nack_pulse = r_nack;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master, frame-level reference model,
// directed scenarios plus randomized frames.
module tb_i2c_codec_target;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic reset;
    logic m_scl;
    logic m_sda;

    i2c_codec_target_if bus ();

    assign bus.i2c_clk = m_scl;
    assign bus.i2c_dat = m_sda & ~bus.i2c_dat_oe;

    i2c_codec_target #(
        .DEV_ADDR   (7'h1A),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_nack  = 0;

    // Frame-level model state: last committed register write.
    logic [6:0] mdl_addr = 7'd0;
    logic [8:0] mdl_data = 9'd0;

    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1)   n_wr++;
        if (bus.nack_pulse === 1'b1) n_nack++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (5) @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b0; q();
        m_scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1; q(); q();
    endtask

    task automatic send_bit(input logic v);
        m_sda = v;    q();
        m_scl = 1'b1; q(); q();
        m_scl = 1'b0; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic ack_bit(output logic ack);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        ack = (bus.i2c_dat === 1'b0);
        q();
        m_scl = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        ack_bit(ack);
    endtask

    // Sends START, bytes, STOP and checks against the frame rules: only a write to
    // 0x34 is ACKed, its first three bytes are ACKed, a full frame writes once.
    task automatic do_frame(input bq_t b, input string tag);
        int   wr0, nk0, exp_wr, exp_nk;
        logic ok, a;
        wr0 = n_wr;
        nk0 = n_nack;
        ok  = (b[0] == 8'h34);
        i2c_start();
        chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
        foreach (b[i]) begin
            send_byte(b[i], a);
            chk($sformatf("%s_ack%0d", tag, i), {31'd0, a}, {31'd0, ok && (i < 3)});
        end
        i2c_stop();
        settle(4);
        exp_wr = (ok && b.size() >= 3) ? 1 : 0;
        exp_nk = ok ? ((b.size() > 3) ? b.size() - 3 : 0) : 1;
        if (exp_wr == 1) begin
            mdl_addr = b[1][7:1];
            mdl_data = {b[1][0], b[2]};
        end
        chk({tag, "_nwr"},   n_wr - wr0,   exp_wr);
        chk({tag, "_nnack"}, n_nack - nk0, exp_nk);
        chk({tag, "_addr"},  {25'd0, bus.wr_addr}, {25'd0, mdl_addr});
        chk({tag, "_data"},  {23'd0, bus.wr_data}, {23'd0, mdl_data});
        chk({tag, "_busy_stop"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bq_t  fr;
        logic a;
        int   wr0, len, guard;

        m_scl = 1'b1;
        m_sda = 1'b1;
        reset = 1'b0;

        // Reset held while the bus toggles: every output stays quiet.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            m_scl = 1'($urandom_range(0, 1));
            m_sda = 1'($urandom_range(0, 1));
            #1;
            chk("rst_outs", {28'd0, bus.i2c_dat_oe, bus.wr_valid, bus.busy, bus.nack_pulse}, 32'd0);
        end
        chk("rst_addr", {25'd0, bus.wr_addr}, 32'd0);
        chk("rst_data", {23'd0, bus.wr_data}, 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        settle(3);
        reset = 1'b1;
        settle(5);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        fr = '{8'h34, 8'h1E, 8'h00}; do_frame(fr, "f0F");
        fr = '{8'h34, 8'h09, 8'hFF}; do_frame(fr, "f04");
        fr = '{8'h34, 8'h0E, 8'h52}; do_frame(fr, "f07");
        fr = '{8'h36, 8'h0E, 8'h52}; do_frame(fr, "badaddr");
        fr = '{8'h35};               do_frame(fr, "rdbit");
        fr = '{8'h34, 8'h08};        do_frame(fr, "short");
        fr = '{8'h34, 8'h08, 8'h14}; do_frame(fr, "f04b");
        fr = '{8'h34, 8'h02, 8'hA5, 8'h11, 8'h22}; do_frame(fr, "long");

        // Repeated START in the middle of byte 2 discards the partial frame.
        wr0 = n_wr;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        send_bits(8'h14, 4);
        chk("rs_nowr", n_wr - wr0, 32'd0);
        fr = '{8'h34, 8'h0E, 8'h52}; do_frame(fr, "rs_full");
        chk("rs_total", n_wr - wr0, 32'd1);

        // Reset asserted while ACKing byte 1.
        wr0 = n_wr;
        i2c_start();
        send_byte(8'h34, a);
        send_bits(8'h1E, 8);
        guard = 0;
        while (bus.i2c_dat_oe !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ack1_oe", {31'd0, bus.i2c_dat_oe}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_oe",   {31'd0, bus.i2c_dat_oe}, 32'd0);
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        mdl_addr = 7'd0;
        mdl_data = 9'd0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        settle(5);
        reset = 1'b1;
        settle(5);
        chk("rstmid_nowr", n_wr - wr0, 32'd0);
        fr = '{8'h34, 8'h0E, 8'h52}; do_frame(fr, "post_rst");

        // Randomized frames: mostly well addressed, lengths 1..4.
        for (int k = 0; k < 16; k++) begin
            fr  = {};
            len = $urandom_range(1, 4);
            fr.push_back(($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255)));
            for (int j = 1; j < len; j++) fr.push_back(8'($urandom_range(0, 255)));
            do_frame(fr, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
